// File: rtl/uart_slave_stream_bridge.sv
// Bus master for the UART slave register port: polls status, moves RX bytes out to a
// valid/ready stream and TX bytes in from one, without CPU involvement.
module uart_slave_stream_bridge #(
  parameter int unsigned POLL_GAP = 4,
  parameter bit          TX_FIRST = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic       o_uart_cs,
  output logic       o_uart_we,
  output logic       o_uart_addr,
  output logic [7:0] o_uart_dat,
  input  logic [7:0] i_uart_dat,
  output logic [7:0] o_rx_dat,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic [7:0] i_tx_dat,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy
);

  localparam logic [7:0] GapReload = 8'(POLL_GAP);

  typedef enum logic [2:0] {StIdle, StStatus, StWrTx, StRdRx, StPopRx} state_e;

  state_e     state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       rx_hold_full_q, rx_hold_full_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_buf_full_q, tx_buf_full_d;
  logic       rr_q, rr_d;

  logic       tx_ok, rx_ok;

  // Status bit 3 = UART TX FIFO full, bit 0 = UART RX FIFO empty.
  assign tx_ok = tx_buf_full_q & ~i_uart_dat[3];
  assign rx_ok = ~rx_hold_full_q & ~i_uart_dat[0];

  assign o_rx_valid = rx_hold_full_q;
  assign o_rx_dat   = rx_hold_q;
  assign o_tx_ready = ~tx_buf_full_q;
  assign o_busy     = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    gap_d          = gap_q;
    rx_hold_d      = rx_hold_q;
    rx_hold_full_d = rx_hold_full_q;
    tx_buf_d       = tx_buf_q;
    tx_buf_full_d  = tx_buf_full_q;
    rr_d           = rr_q;
    o_uart_cs      = 1'b0;
    o_uart_we      = 1'b0;
    o_uart_addr    = 1'b0;
    o_uart_dat     = 8'h00;

    if (i_tx_valid && !tx_buf_full_q) begin
      tx_buf_d      = i_tx_dat;
      tx_buf_full_d = 1'b1;
    end
    if (rx_hold_full_q && i_rx_ready) begin
      rx_hold_full_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (tx_buf_full_q || !rx_hold_full_q) begin
          state_d = StStatus;
        end
      end
      StStatus: begin
        o_uart_cs = 1'b1;
        if (tx_ok && rx_ok) begin
          state_d = rr_q ? StWrTx : StRdRx;
        end else if (tx_ok) begin
          state_d = StWrTx;
        end else if (rx_ok) begin
          state_d = StRdRx;
        end else begin
          state_d = StIdle;
          gap_d   = GapReload;
        end
      end
      StWrTx: begin
        o_uart_cs     = 1'b1;
        o_uart_we     = 1'b1;
        o_uart_addr   = 1'b1;
        o_uart_dat    = tx_buf_q;
        tx_buf_full_d = 1'b0;
        rr_d          = 1'b0;
        state_d       = StIdle;
        gap_d         = GapReload;
      end
      StRdRx: begin
        o_uart_cs      = 1'b1;
        o_uart_addr    = 1'b1;
        rx_hold_d      = i_uart_dat;
        rx_hold_full_d = 1'b1;
        state_d        = StPopRx;
      end
      StPopRx: begin
        o_uart_cs = 1'b1;
        o_uart_we = 1'b1;
        rr_d      = 1'b1;
        state_d   = StIdle;
        gap_d     = GapReload;
      end
      default: begin
        state_d = StIdle;
        gap_d   = GapReload;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= StIdle;
      gap_q          <= GapReload;
      rx_hold_q      <= 8'h00;
      rx_hold_full_q <= 1'b0;
      tx_buf_q       <= 8'h00;
      tx_buf_full_q  <= 1'b0;
      rr_q           <= TX_FIRST;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      rx_hold_q      <= rx_hold_d;
      rx_hold_full_q <= rx_hold_full_d;
      tx_buf_q       <= tx_buf_d;
      tx_buf_full_q  <= tx_buf_full_d;
      rr_q           <= rr_d;
    end
  end

endmodule

// File: tb/tb_uart_slave_stream_bridge.sv
// Directed bench for uart_slave_stream_bridge with a small behavioural UART slave model.
module tb_uart_slave_stream_bridge;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       o_uart_cs, o_uart_we, o_uart_addr;
  logic [7:0] o_uart_dat, uart_rdat;
  logic [7:0] o_rx_dat;
  logic       o_rx_valid;
  logic       i_rx_ready = 1'b0;
  logic [7:0] i_tx_dat = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready, o_busy;

  uart_slave_stream_bridge #(.POLL_GAP(0), .TX_FIRST(1'b1)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .o_uart_cs  (o_uart_cs),
    .o_uart_we  (o_uart_we),
    .o_uart_addr(o_uart_addr),
    .o_uart_dat (o_uart_dat),
    .i_uart_dat (uart_rdat),
    .o_rx_dat   (o_rx_dat),
    .o_rx_valid (o_rx_valid),
    .i_rx_ready (i_rx_ready),
    .i_tx_dat   (i_tx_dat),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // UART slave model: RX FIFO, controllable TX-full flag, log of bus accesses.
  logic [7:0] rx_mem [32];
  logic [4:0] rx_head = 5'd0;
  logic [4:0] rx_tail = 5'd0;
  logic       uart_tx_full = 1'b0;
  logic [7:0] wr_log [16];
  int         acc_log [32];
  int         wr_cnt = 0, st_cnt = 0, rd_cnt = 0, acc_cnt = 0;

  // Upper nibble deliberately nonzero: those bits must be ignored.
  assign uart_rdat = (o_uart_cs && o_uart_addr && !o_uart_we) ? rx_mem[rx_head] :
                     {4'hA, uart_tx_full, ~uart_tx_full, 1'b0, (rx_head == rx_tail)};

  always @(posedge i_clk) begin
    if (o_uart_cs) begin
      if (o_uart_we && o_uart_addr) begin
        wr_log[wr_cnt]   <= o_uart_dat;
        wr_cnt           <= wr_cnt + 1;
        acc_log[acc_cnt] <= 1;
        acc_cnt          <= acc_cnt + 1;
      end else if (o_uart_we) begin
        rx_head <= rx_head + 5'd1;
      end else if (o_uart_addr) begin
        rd_cnt           <= rd_cnt + 1;
        acc_log[acc_cnt] <= 2;
        acc_cnt          <= acc_cnt + 1;
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] outs();
    return {o_uart_cs, o_uart_we, o_uart_addr, o_uart_dat,
            o_rx_valid, o_rx_dat, o_tx_ready, o_busy};
  endfunction

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_tail] = b;
    rx_tail = rx_tail + 5'd1;
  endtask

  task automatic wait_rx();
    int n = 0;
    while (!o_rx_valid && n < 50) begin
      @(negedge i_clk); #1; n++;
    end
  endtask

  task automatic pop_rx();
    i_rx_ready = 1'b1;
    @(negedge i_clk);
    i_rx_ready = 1'b0;
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    while (!o_tx_ready && n < 50) begin
      @(negedge i_clk); #1; n++;
    end
    chk("tx_ready_before_send", 32'(o_tx_ready), 32'd1);
    i_tx_valid = 1'b1;
    i_tx_dat   = b;
    @(negedge i_clk);
    i_tx_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        tx_valid;
    logic [7:0]  tx_dat;
    logic        rx_ready;
    logic [21:0] exp;
  } vec_t;

  function automatic vec_t v(logic tv, logic [7:0] td, logic rr, logic cs, logic we, logic ad,
                             logic [7:0] ud, logic rv, logic [7:0] rd, logic trdy, logic busy);
    vec_t r;
    r.tx_valid = tv;
    r.tx_dat   = td;
    r.rx_ready = rr;
    r.exp      = {cs, we, ad, ud, rv, rd, trdy, busy};
    return r;
  endfunction

  vec_t       tbl [12];
  logic [7:0] txb [3];
  logic [7:0] rxb [3];
  int         exp_acc [4];
  int         base_wr, base_st, base_rd, base_acc, ti, ri, n;
  logic       ok;

  initial begin
    #100000;
    $display("watchdog timeout, bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //        tv  td     rr  cs we ad dat    rv rd     trdy busy
    tbl[0]  = v(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0);  // idle after reset
    tbl[1]  = v(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1);  // status read
    tbl[2]  = v(0, 8'h00, 1, 1, 0, 1, 8'h00, 0, 8'h00, 1, 1);  // data read
    tbl[3]  = v(0, 8'h00, 1, 1, 1, 0, 8'h00, 1, 8'h41, 1, 1);  // pop, byte visible
    tbl[4]  = v(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h41, 1, 0);
    tbl[5]  = v(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h41, 1, 1);  // empty poll
    tbl[6]  = v(1, 8'h55, 1, 0, 0, 0, 8'h00, 0, 8'h41, 1, 0);  // offer 0x55
    tbl[7]  = v(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h41, 0, 1);
    tbl[8]  = v(0, 8'h00, 1, 1, 1, 1, 8'h55, 0, 8'h41, 0, 1);  // write 0x55
    tbl[9]  = v(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h41, 1, 0);  // ready back
    tbl[10] = v(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h41, 1, 1);
    tbl[11] = v(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h41, 1, 0);

    push_rx(8'h41);
    repeat (2) @(negedge i_clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'h2);
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge i_clk);
      i_tx_valid = tbl[i].tx_valid;
      i_tx_dat   = tbl[i].tx_dat;
      i_rx_ready = tbl[i].rx_ready;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    chk("single_write_count", 32'(wr_cnt), 32'd1);
    chk("write_data_55", 32'(wr_log[0]), 32'h55);
    i_rx_ready = 1'b0;

    // Async reset in the middle of an RX data read.
    push_rx(8'h77);
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("in_rd_rx", 32'({o_uart_cs, o_uart_we, o_uart_addr}), 32'b101);
    #1;
    i_reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(outs()), 32'h2);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("released_idle", 32'(outs()), 32'h2);
    wait_rx();
    chk("rx_after_reset", 32'({o_rx_valid, o_rx_dat}), 32'h177);
    pop_rx();

    // Consumer stalls: held byte stays put and no further reads happen.
    push_rx(8'h33);
    push_rx(8'h34);
    wait_rx();
    chk("hold_33", 32'({o_rx_valid, o_rx_dat}), 32'h133);
    @(negedge i_clk);
    #1;
    base_rd = rd_cnt;
    ok = 1'b1;
    repeat (20) begin
      @(negedge i_clk); #1;
      if (!o_rx_valid || o_rx_dat !== 8'h33) ok = 1'b0;
    end
    chk("hold_stable", 32'(ok), 32'd1);
    chk("no_read_while_full", 32'(rd_cnt), 32'(base_rd));
    pop_rx();
    wait_rx();
    chk("next_34", 32'({o_rx_valid, o_rx_dat}), 32'h134);
    pop_rx();

    // UART TX FIFO full for three polls, then drains.
    uart_tx_full = 1'b1;
    send_tx(8'hA5);
    base_wr = wr_cnt;
    base_st = st_cnt;
    ok = 1'b1;
    n = 0;
    while (st_cnt < base_st + 3 && n < 100) begin
      @(negedge i_clk); #1; n++;
      if (o_tx_ready) ok = 1'b0;
    end
    chk("three_full_polls", 32'(st_cnt), 32'(base_st + 3));
    chk("no_write_while_full", 32'(wr_cnt), 32'(base_wr));
    uart_tx_full = 1'b0;
    n = 0;
    while (wr_cnt == base_wr && n < 20) begin
      if (o_tx_ready) ok = 1'b0;
      @(negedge i_clk); #1; n++;
    end
    chk("tx_ready_low_while_held", 32'(ok), 32'd1);
    chk("retry_write_data", 32'(wr_log[base_wr]), 32'hA5);
    chk("tx_ready_after_write", 32'(o_tx_ready), 32'd1);
    repeat (6) @(negedge i_clk);
    #1;
    chk("retry_single_write", 32'(wr_cnt), 32'(base_wr + 1));

    // Both directions pending after reset: round-robin starting with TX.
    i_reset = 1'b1;
    push_rx(8'h20);
    push_rx(8'h21);
    txb[0] = 8'h10; txb[1] = 8'h11; txb[2] = 8'h00;
    rxb[0] = 8'h20; rxb[1] = 8'h21; rxb[2] = 8'h00;
    exp_acc[0] = 1; exp_acc[1] = 2; exp_acc[2] = 1; exp_acc[3] = 2;
    base_acc = acc_cnt;
    base_wr  = wr_cnt;
    ti = 0;
    ri = 0;
    n  = 0;
    i_rx_ready = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    while (!(ti == 2 && ri == 2 && wr_cnt >= base_wr + 2) && n < 80) begin
      i_tx_valid = (ti < 2);
      i_tx_dat   = txb[ti];
      #1;
      if (i_tx_valid && o_tx_ready) ti++;
      if (o_rx_valid && i_rx_ready) begin
        chk($sformatf("rr_rx_byte%0d", ri), 32'(o_rx_dat), 32'(rxb[ri]));
        ri++;
      end
      @(negedge i_clk);
      n++;
    end
    i_tx_valid = 1'b0;
    i_rx_ready = 1'b0;
    chk("rr_tx_accepted", 32'(ti), 32'd2);
    chk("rr_rx_delivered", 32'(ri), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_order%0d", k), 32'(acc_log[base_acc + k]), 32'(exp_acc[k]));
    end
    chk("rr_tx_byte0", 32'(wr_log[base_wr]), 32'h10);
    chk("rr_tx_byte1", 32'(wr_log[base_wr + 1]), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
